// File: rtl/vg_vec_timer_p_if.sv
// Handshake bundle between the VG state machine and the vector-duration timer.
interface vg_vec_timer_p_if #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned SCALE_W = 4
);
  logic               start;
  logic               short;
  logic [SCALE_W-1:0] scale;
  logic               hold;
  logic               abort;
  logic               go;
  logic               stop_n;
  logic               busy;
  logic               done;
  logic [CNT_W:0]     remaining;

  modport master (
    output start, short, scale, hold, abort,
    input  go, stop_n, busy, done, remaining
  );

  modport slave (
    input  start, short, scale, hold, abort,
    output go, stop_n, busy, done, remaining
  );
endinterface

// File: rtl/vg_vec_timer_p.sv
// Vector-duration timer: loads a power-of-two length at start and issues one
// integrator enable per active clock, with hold, abort and remaining readout.
module vg_vec_timer_p #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned SHORT_W = 7,
  parameter int unsigned SCALE_W = 4
) (
  input logic             clk_12MHz,
  input logic             reset,
  vg_vec_timer_p_if.slave bus
);

  localparam int RemW = CNT_W + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic              done_q, done_d;
  logic [RemW-1:0]   n_len;
  int                exp_len;
  logic              go_w;

  // Length exponent is signed so large scales saturate to a single clock.
  always_comb begin
    exp_len = (bus.short ? int'(SHORT_W) : int'(CNT_W)) - int'(bus.scale);
    n_len   = RemW'(1);
    if (exp_len >= 1) begin
      n_len = RemW'(1) << exp_len;
    end
  end

  assign go_w = (state_q == StRun) && !bus.hold;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d = StRun;
          rem_d   = n_len;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (!bus.hold) begin
          rem_d = rem_q - RemW'(1);
          if (rem_q == RemW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign bus.go        = go_w;
  assign bus.stop_n    = !(go_w && (rem_q == RemW'(1)));
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_vg_vec_timer_p.sv
// Self-checking bench for vg_vec_timer_p: directed scenarios plus random traffic
// compared every cycle against a cycle-count reference model.
module tb_vg_vec_timer_p;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned SHORT_W = 7;
  localparam int unsigned SCALE_W = 4;

  logic clk_12MHz = 1'b0;
  logic reset;

  always #5 clk_12MHz = ~clk_12MHz;

  vg_vec_timer_p_if #(.CNT_W(CNT_W), .SCALE_W(SCALE_W)) bus ();

  vg_vec_timer_p #(
    .CNT_W  (CNT_W),
    .SHORT_W(SHORT_W),
    .SCALE_W(SCALE_W)
  ) dut (
    .clk_12MHz(clk_12MHz),
    .reset    (reset),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: whether a vector is active, go cycles still owed, done pending.
  bit m_run;
  int m_rem;
  bit m_done;

  int n_go, n_stop, n_done, cyc, t_done;

  function automatic int vec_len(input bit s, input int sc);
    int e;
    e = (s ? int'(SHORT_W) : int'(CNT_W)) - sc;
    return (e >= 1) ? (1 << e) : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_go = 0; n_stop = 0; n_done = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic tick();
    bit exp_go;
    @(negedge clk_12MHz);
    exp_go = m_run && !bus.hold;
    check("busy", 32'(bus.busy), 32'(m_run));
    check("go", 32'(bus.go), 32'(exp_go));
    check("stop_n", 32'(bus.stop_n), 32'(!(exp_go && m_rem == 1)));
    check("done", 32'(bus.done), 32'(m_done));
    check("remaining", 32'(bus.remaining), 32'(m_rem));
    if (bus.go === 1'b1) n_go++;
    if (bus.stop_n === 1'b0) n_stop++;
    if (bus.done === 1'b1) begin n_done++; t_done = cyc; end
    cyc++;
    @(posedge clk_12MHz);
    if (reset) begin
      m_run = 0; m_rem = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (bus.start && !bus.abort) begin
        m_run = 1;
        m_rem = vec_len(bus.short, int'(bus.scale));
      end
    end else begin
      m_done = 0;
      if (bus.abort) begin
        m_run = 0; m_rem = 0;
      end else if (!bus.hold) begin
        m_rem--;
        if (m_rem == 0) begin m_run = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic start_vec(input bit s, input int sc);
    bus.short = s;
    bus.scale = SCALE_W'(sc);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while (m_run && k < max) begin tick(); k++; end
    check("vector_ends_in_budget", 32'(m_run), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    m_run = 0; m_rem = 0; m_done = 0; cyc = 0; t_done = -1;
    reset = 1'b1;
    bus.start = 0; bus.short = 0; bus.scale = '0; bus.hold = 0; bus.abort = 0;
    @(posedge clk_12MHz); #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_stop_n", 32'(bus.stop_n), 32'd1);

    // Long full-length vector.
    clear_counts();
    start_vec(0, 0);
    check("long_busy", 32'(bus.busy), 32'd1);
    check("long_len", 32'(bus.remaining), 32'd1024);
    run_idle(1100);
    tick();
    check("long_gos", n_go, 1024);
    check("long_stops", n_stop, 1);
    check("long_dones", n_done, 1);

    // Short scaled vector.
    clear_counts();
    start_vec(1, 3);
    check("short_len", 32'(bus.remaining), 32'd16);
    run_idle(40);
    tick();
    check("short_gos", n_go, 16);
    check("short_stops", n_stop, 1);
    check("short_dones", n_done, 1);

    // Saturation to a single clock.
    clear_counts();
    start_vec(0, 12);
    check("sat_len", 32'(bus.remaining), 32'd1);
    run_idle(4);
    tick();
    check("sat_gos", n_go, 1);
    check("sat_stops", n_stop, 1);
    check("sat_dones", n_done, 1);

    // Hold for five clocks after the fourth go.
    clear_counts();
    start_vec(0, 6);
    t0 = cyc;
    repeat (4) tick();
    bus.hold = 1'b1;
    repeat (5) tick();
    check("hold_frozen", 32'(bus.remaining), 32'd12);
    bus.hold = 1'b0;
    run_idle(40);
    tick();
    check("hold_gos", n_go, 16);
    check("hold_dones", n_done, 1);
    check("hold_done_clock", t_done - t0 + 1, 22);

    // Start while busy is ignored; abort at go 20 ends without done.
    clear_counts();
    start_vec(1, 0);
    repeat (9) tick();
    bus.start = 1'b1; bus.short = 0; bus.scale = '0;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rem", 32'(bus.remaining), 32'd0);
    repeat (2) tick();
    check("abort_gos", n_go, 20);
    check("abort_dones", n_done, 0);

    // Start together with abort in idle.
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_idle", 32'(bus.busy), 32'd0);
    tick();

    // Reset in the middle of a vector.
    start_vec(0, 0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_rem", 32'(bus.remaining), 32'd0);
    check("midreset_go", 32'(bus.go), 32'd0);
    tick();

    // Back-to-back: start in the done cycle.
    clear_counts();
    start_vec(0, 8);
    repeat (4) tick();
    check("b2b_done_cycle", 32'(bus.done), 32'd1);
    start_vec(0, 8);
    check("b2b_accepted", 32'(bus.busy), 32'd1);
    check("b2b_len", 32'(bus.remaining), 32'd4);
    run_idle(10);
    tick();
    check("b2b_gos", n_go, 8);
    check("b2b_dones", n_done, 2);

    // Random traffic against the model.
    repeat (400) begin
      bus.start = ($urandom_range(3) == 0);
      bus.short = $urandom_range(1) == 1;
      bus.scale = SCALE_W'($urandom_range(15));
      bus.hold  = ($urandom_range(3) == 0);
      bus.abort = ($urandom_range(31) == 0);
      reset     = ($urandom_range(127) == 0);
      tick();
    end
    reset = 1'b0; bus.start = 0; bus.hold = 0; bus.abort = 0;
    run_idle(1200);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vg_vec_timer_p.md
Name: vg_vec_timer_p

Overview:
Parametrised vector-duration timer for the vector generator. It replaces the fixed 15-bit A/B/C/D chained-counter timer and its multi-cycle shift-load scale.
- On a start request it loads the draw duration in a single cycle. The duration is a power of two set by the binary scale and the short/long vector mode.
- It then issues one integrator-enable (go) per active clock, drops stop_n on the final active clock and pulses done.
- Adds hold (pause), abort and a remaining-count readout.
- Sits between the VG state machine (start/short/scale) and the X/Y DAC integrator enables.

Parameters:
- CNT_W, 10, log2 of the longest (long-mode, scale=0) vector duration in clocks.
- SHORT_W, 7, log2 of the short-mode, scale=0 duration. Must satisfy 1 <= SHORT_W < CNT_W.
- SCALE_W, 4, width of the binary scale input.

Ports:
- clk_12MHz  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a vector; sampled only in IDLE.
- short  in  1  1 = short vector (SHORT_W), 0 = long vector (CNT_W); sampled with start.
- scale  in  SCALE_W  binary scale shift, unsigned; sampled with start.
- hold  in  1  pauses counting while high in RUN.
- abort  in  1  terminates the vector at once with no done pulse.
- go  out  1  integrator enable; = busy & ~hold (combinational).
- stop_n  out  1  active-low terminal flag; low only during the final go cycle (combinational).
- busy  out  1  registered; high in RUN.
- done  out  1  registered one-cycle pulse after completion.
- remaining  out  CNT_W+1  go cycles still to issue; 0 in IDLE.

Behaviour:
- Reset is synchronous, active-high. The reset values are state=IDLE, busy=0, done=0 and remaining=0; therefore go=0 and stop_n=1. Reset overrides every other input, including in the middle of a vector.
- Length computation, done at start:
  - W = short ? SHORT_W : CNT_W; E = W - scale, computed signed.
  - E >= 1 gives N = 2^E. E <= 0 saturates to N = 1.
  - N never exceeds 2^CNT_W, so remaining is CNT_W+1 bits wide.
- IDLE state:
  - done=0 by default.
  - If start=1 and abort=0: remaining <= N, busy <= 1, state <= RUN. busy rises one clock after start.
  - If start and abort are both high, abort wins and the block stays IDLE.
- RUN state, go=1 when hold=0:
  - Each go cycle decrements remaining by 1.
  - stop_n = ~(go & remaining==1).
  - On the go cycle with remaining==1: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle, and remaining reaches 0.
  - Exactly N go cycles are issued per vector, whatever the hold pattern.
- hold=1 in RUN: go=0, stop_n=1 and remaining is frozen. hold has no effect in IDLE.
- abort=1 in RUN, taking priority over hold and over the final cycle:
  - go and stop_n are unaffected in the abort cycle itself, since both are combinational.
  - Next clock: state=IDLE, busy=0, remaining=0, and done stays 0.
- start while busy=1 is ignored and not queued.
- The done cycle is an IDLE cycle, so a start asserted together with done is accepted. This gives a minimum one-cycle gap between the last go of one vector and the first go of the next.
- short and scale are ignored outside the start acceptance cycle. They may change freely in RUN.

Test Plan:
- Long full-length vector: reset, then start=1 with short=0, scale=0, hold=0 for one clock.
  - Required: busy=1 on the next clock, then exactly 1024 go cycles.
  - stop_n=0 only on go cycle 1024; done=1 on the following clock; busy=0 and remaining=0 afterwards.
- Short scaled vector: start with short=1, scale=3.
  - Required: N=16, remaining reads 16 after load, 16 go cycles, stop_n low once, one done pulse.
- Saturation: start with short=0, scale=12 (E=-2).
  - Required: N=1; single go cycle with stop_n=0 in the same cycle; done on the next clock.
- Hold: long vector with scale=6 (N=16); hold=1 for 5 clocks after the 4th go.
  - Required: remaining stays at 12 during the hold, go=0 and stop_n=1 throughout.
  - Total go cycles = 16; done 22 clocks after busy rises.
- Abort, start-while-busy and reset:
  - In a short scale=0 vector (N=128): a start at go #10 is ignored. abort at go #20 gives busy=0 and remaining=0 next clock, with no done.
  - start together with abort in IDLE leaves the block idle.
  - A second vector reset at go #5 returns all outputs to their reset values on the next clock.
- Back-to-back vectors: assert start in the done cycle of a scale=8 long vector (N=4).
  - Required: the new vector is accepted, with exactly one go-free cycle between the two vectors' go runs.
